// File: rtl/dmem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_port_arbiter
// Purpose  : Shares the data-memory port between the CPU Mem stage and an
//            external master, inserting WAIT_STATES cycles per access.
// Revision : 1.0
// ============================================================================
module dmem_port_arbiter #(
   parameter int WAIT_STATES = 2
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   output logic [31:0] cpu_rdata,
   output logic        cpu_done,
   output logic        cpu_stall,
   input  logic        ext_req,
   input  logic        ext_we,
   input  logic [31:0] ext_addr,
   input  logic [31:0] ext_wdata,
   output logic [31:0] ext_rdata,
   output logic        ext_done,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        mem_re,
   output logic        mem_we,
   input  logic [31:0] mem_rdata,
   output logic        grant_ext
);

   localparam logic [3:0] C_WAIT = 4'(WAIT_STATES);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_DONE   = 2'd2
   } state_t;

   state_t      r_state;
   logic [3:0]  r_count;
   logic        r_owner_ext;
   logic        r_last_ext;
   logic        r_we;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [31:0] r_cpu_rdata;
   logic [31:0] r_ext_rdata;
   logic        r_mem_re;
   logic        r_mem_we;
   logic        r_cpu_done;
   logic        r_ext_done;
   logic        r_grant_ext;

   logic        w_grant_cpu;
   logic        w_grant_ext;
   logic        w_sel_we;
   logic [31:0] w_sel_addr;
   logic [31:0] w_sel_wdata;

   // Round-robin: on a tie the port that was not served last wins.
   always_comb begin
      w_grant_cpu = cpu_req & (~ext_req | r_last_ext);
      w_grant_ext = ext_req & (~cpu_req | ~r_last_ext);
      w_sel_we    = w_grant_ext ? ext_we    : cpu_we;
      w_sel_addr  = w_grant_ext ? ext_addr  : cpu_addr;
      w_sel_wdata = w_grant_ext ? ext_wdata : cpu_wdata;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= S_IDLE;
         r_count     <= 4'd0;
         r_owner_ext <= 1'b0;
         r_last_ext  <= 1'b1;
         r_we        <= 1'b0;
         r_addr      <= 32'd0;
         r_wdata     <= 32'd0;
         r_cpu_rdata <= 32'd0;
         r_ext_rdata <= 32'd0;
         r_mem_re    <= 1'b0;
         r_mem_we    <= 1'b0;
         r_cpu_done  <= 1'b0;
         r_ext_done  <= 1'b0;
         r_grant_ext <= 1'b0;
      end else begin
         r_cpu_done <= 1'b0;
         r_ext_done <= 1'b0;
         r_mem_we   <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_grant_cpu | w_grant_ext) begin
                  r_owner_ext <= w_grant_ext;
                  r_last_ext  <= w_grant_ext;
                  r_grant_ext <= w_grant_ext;
                  r_we        <= w_sel_we;
                  r_addr      <= w_sel_addr;
                  r_wdata     <= w_sel_wdata;
                  r_count     <= C_WAIT;
                  r_mem_re    <= 1'b1;
                  // With no wait states the first access cycle is also the last.
                  r_mem_we    <= w_sel_we & (C_WAIT == 4'd0);
                  r_state     <= S_ACCESS;
               end
            end
            S_ACCESS: begin
               if (r_count != 4'd0) begin
                  r_count  <= r_count - 4'd1;
                  r_mem_we <= r_we & (r_count == 4'd1);
               end else begin
                  r_mem_re <= 1'b0;
                  if (!r_we) begin
                     if (r_owner_ext) r_ext_rdata <= mem_rdata;
                     else             r_cpu_rdata <= mem_rdata;
                  end
                  r_cpu_done <= ~r_owner_ext;
                  r_ext_done <= r_owner_ext;
                  r_state    <= S_DONE;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign cpu_rdata = r_cpu_rdata;
   assign ext_rdata = r_ext_rdata;
   assign cpu_done  = r_cpu_done;
   assign ext_done  = r_ext_done;
   assign cpu_stall = cpu_req & ~r_cpu_done;
   assign mem_addr  = r_addr;
   assign mem_wdata = r_wdata;
   assign mem_re    = r_mem_re;
   assign mem_we    = r_mem_we;
   assign grant_ext = r_grant_ext;

endmodule
`default_nettype wire

// File: tb/tb_dmem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_port_arbiter
// Purpose  : Directed scoreboard bench for dmem_port_arbiter (WAIT_STATES 2 and 0).
// Revision : 1.0
// ============================================================================
module tb_dmem_port_arbiter;

   typedef struct packed {
      logic        port;
      logic [31:0] rdata;
   } done_t;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] d;
   } wr_t;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   logic        cpu_req = 1'b0, cpu_we = 1'b0, ext_req = 1'b0, ext_we = 1'b0;
   logic [31:0] cpu_addr = '0, cpu_wdata = '0, ext_addr = '0, ext_wdata = '0;
   logic [31:0] cpu_rdata, ext_rdata, mem_addr, mem_wdata, mem_rdata;
   logic        cpu_done, cpu_stall, ext_done, mem_re, mem_we, grant_ext;

   logic        cpu_req0 = 1'b0, cpu_we0 = 1'b0, ext_req0 = 1'b0, ext_we0 = 1'b0;
   logic [31:0] cpu_addr0 = '0, cpu_wdata0 = '0, ext_addr0 = '0, ext_wdata0 = '0;
   logic [31:0] cpu_rdata0, ext_rdata0, mem_addr0, mem_wdata0, mem_rdata0;
   logic        cpu_done0, cpu_stall0, ext_done0, mem_re0, mem_we0, grant_ext0;

   int n_pass = 0;
   int n_total = 0;

   done_t q_done[$];
   done_t q_done0[$];
   wr_t   q_wr[$];

   function automatic logic [31:0] rom(input logic [31:0] a);
      case (a)
         32'h100: rom = 32'hDEADBEEF;
         32'h040: rom = 32'h1111_0040;
         32'h080: rom = 32'h2222_0080;
         default: rom = 32'hA5A5_A5A5;
      endcase
   endfunction

   assign mem_rdata  = rom(mem_addr);
   assign mem_rdata0 = rom(mem_addr0);

   dmem_port_arbiter #(.WAIT_STATES(2)) dut (
      .clk(clk), .reset_n(reset_n),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_done(cpu_done), .cpu_stall(cpu_stall),
      .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
      .ext_rdata(ext_rdata), .ext_done(ext_done),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_re(mem_re), .mem_we(mem_we),
      .mem_rdata(mem_rdata), .grant_ext(grant_ext)
   );

   dmem_port_arbiter #(.WAIT_STATES(0)) dut0 (
      .clk(clk), .reset_n(reset_n),
      .cpu_req(cpu_req0), .cpu_we(cpu_we0), .cpu_addr(cpu_addr0), .cpu_wdata(cpu_wdata0),
      .cpu_rdata(cpu_rdata0), .cpu_done(cpu_done0), .cpu_stall(cpu_stall0),
      .ext_req(ext_req0), .ext_we(ext_we0), .ext_addr(ext_addr0), .ext_wdata(ext_wdata0),
      .ext_rdata(ext_rdata0), .ext_done(ext_done0),
      .mem_addr(mem_addr0), .mem_wdata(mem_wdata0), .mem_re(mem_re0), .mem_we(mem_we0),
      .mem_rdata(mem_rdata0), .grant_ext(grant_ext0)
   );

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %08h expected %08h", name, act, exp);
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0b expected %0b", name, act, exp);
   endtask

   // Monitor: pops expected completions and writes as the DUTs present them.
   always @(negedge clk) begin
      done_t d;
      wr_t   w;
      if (cpu_done || ext_done) begin
         chk1("done_exclusive", cpu_done & ext_done, 1'b0);
         if (q_done.size() == 0) begin
            chk1("done_unexpected", 1'b1, 1'b0);
         end else begin
            d = q_done.pop_front();
            chk1("done_port", ext_done, d.port);
            chk32("done_rdata", ext_done ? ext_rdata : cpu_rdata, d.rdata);
         end
      end
      if (mem_we) begin
         chk1("we_inside_access", mem_re, 1'b1);
         if (q_wr.size() == 0) begin
            chk1("write_unexpected", 1'b1, 1'b0);
         end else begin
            w = q_wr.pop_front();
            chk32("write_addr", mem_addr, w.a);
            chk32("write_data", mem_wdata, w.d);
         end
      end
      if (cpu_done0 || ext_done0) begin
         if (q_done0.size() == 0) begin
            chk1("ws0_done_unexpected", 1'b1, 1'b0);
         end else begin
            d = q_done0.pop_front();
            chk1("ws0_done_port", ext_done0, d.port);
            chk32("ws0_done_rdata", ext_done0 ? ext_rdata0 : cpu_rdata0, d.rdata);
         end
      end
      if (mem_we0) chk1("ws0_write_unexpected", mem_we0, 1'b0);
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      // Reset values
      repeat (2) @(negedge clk);
      chk32("rst_ctrl", {26'd0, mem_re, mem_we, cpu_done, ext_done, cpu_stall, grant_ext}, 32'd0);
      chk32("rst_mem_addr", mem_addr, 32'd0);
      chk32("rst_mem_wdata", mem_wdata, 32'd0);
      chk32("rst_rdata", cpu_rdata | ext_rdata, 32'd0);
      reset_n = 1'b1;
      @(negedge clk);

      // CPU load, 2 wait states
      q_done.push_back(done_t'{1'b0, 32'hDEADBEEF});
      cpu_we = 1'b0; cpu_addr = 32'h100; cpu_req = 1'b1;
      #1 chk1("load_stall_t0", cpu_stall, 1'b1);
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         chk1("load_mem_re", mem_re, k <= 3);
         if (k <= 3) chk32("load_mem_addr", mem_addr, 32'h100);
         chk1("load_mem_we", mem_we, 1'b0);
         chk1("load_cpu_done", cpu_done, k == 4);
         chk1("load_stall", cpu_stall, k <= 3);
      end
      cpu_req = 1'b0;
      @(negedge clk);

      // External store
      q_wr.push_back(wr_t'{32'h20, 32'h12345678});
      q_done.push_back(done_t'{1'b1, 32'h0});
      ext_we = 1'b1; ext_addr = 32'h20; ext_wdata = 32'h12345678; ext_req = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         chk1("store_mem_we", mem_we, k == 3);
         if (k == 3) chk32("store_mem_addr", mem_addr, 32'h20);
         if (k == 3) chk32("store_mem_wdata", mem_wdata, 32'h12345678);
         chk1("store_ext_done", ext_done, k == 4);
         chk1("store_grant_ext", grant_ext, 1'b1);
         chk32("store_cpu_rdata_kept", cpu_rdata, 32'hDEADBEEF);
      end
      ext_req = 1'b0; ext_we = 1'b0;
      @(negedge clk);

      // Both ports held: CPU, EXT, CPU, EXT
      q_done.push_back(done_t'{1'b0, 32'h1111_0040});
      q_done.push_back(done_t'{1'b1, 32'h2222_0080});
      q_done.push_back(done_t'{1'b0, 32'h1111_0040});
      q_done.push_back(done_t'{1'b1, 32'h2222_0080});
      cpu_we = 1'b0; cpu_addr = 32'h40; cpu_req = 1'b1;
      ext_we = 1'b0; ext_addr = 32'h80; ext_req = 1'b1;
      for (int k = 1; k <= 19; k++) begin
         @(negedge clk);
         chk1("rr_cpu_done", cpu_done, (k == 4) || (k == 14));
         chk1("rr_ext_done", ext_done, (k == 9) || (k == 19));
         chk1("rr_stall", cpu_stall, (k != 4) && (k != 14));
         chk1("rr_grant_ext", grant_ext, ((k >= 6) && (k <= 10)) || (k >= 16));
         chk1("rr_mem_we", mem_we, 1'b0);
      end
      cpu_req = 1'b0; ext_req = 1'b0;
      @(negedge clk);

      // Zero wait states, request held
      q_done0.push_back(done_t'{1'b0, 32'h1111_0040});
      q_done0.push_back(done_t'{1'b0, 32'h1111_0040});
      q_done0.push_back(done_t'{1'b0, 32'h1111_0040});
      cpu_we0 = 1'b0; cpu_addr0 = 32'h40; cpu_req0 = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         chk1("ws0_cpu_done", cpu_done0, (k == 2) || (k == 5) || (k == 8));
         chk1("ws0_mem_re", mem_re0, (k == 1) || (k == 4) || (k == 7));
      end
      cpu_req0 = 1'b0;
      @(negedge clk);

      // CPU store with request dropped mid-access and fields scrambled
      q_wr.push_back(wr_t'{32'h200, 32'hCAFEF00D});
      q_done.push_back(done_t'{1'b0, 32'h1111_0040});
      cpu_we = 1'b1; cpu_addr = 32'h200; cpu_wdata = 32'hCAFEF00D; cpu_req = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         chk1("drop_mem_we", mem_we, k == 3);
         chk1("drop_mem_re", mem_re, k <= 3);
         if (k <= 3) chk32("drop_mem_addr", mem_addr, 32'h200);
         if (k <= 3) chk32("drop_mem_wdata", mem_wdata, 32'hCAFEF00D);
         chk1("drop_cpu_done", cpu_done, k == 4);
         chk1("drop_stall", cpu_stall, k <= 2);
         if (k == 2) begin
            cpu_req = 1'b0; cpu_addr = 32'hFFFF_FFF0; cpu_wdata = 32'd0;
         end
      end

      // Reset during the write cycle of a store
      q_wr.push_back(wr_t'{32'h300, 32'h0BADF00D});
      cpu_we = 1'b1; cpu_addr = 32'h300; cpu_wdata = 32'h0BADF00D; cpu_req = 1'b1;
      for (int k = 1; k <= 3; k++) @(negedge clk);
      chk1("abort_we_before", mem_we, 1'b1);
      #2;
      reset_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
      #1;
      chk32("abort_ctrl", {26'd0, mem_re, mem_we, cpu_done, ext_done, cpu_stall, grant_ext}, 32'd0);
      chk32("abort_mem_addr", mem_addr, 32'd0);
      chk32("abort_rdata", cpu_rdata | ext_rdata, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      // First tie after reset goes to the CPU
      q_done.push_back(done_t'{1'b0, 32'h1111_0040});
      q_done.push_back(done_t'{1'b1, 32'h2222_0080});
      cpu_addr = 32'h40; cpu_req = 1'b1;
      ext_we = 1'b0; ext_addr = 32'h80; ext_req = 1'b1;
      for (int k = 1; k <= 9; k++) begin
         @(negedge clk);
         chk1("tie_cpu_done", cpu_done, k == 4);
         chk1("tie_ext_done", ext_done, k == 9);
         chk1("tie_grant_ext", grant_ext, k >= 6);
      end
      cpu_req = 1'b0; ext_req = 1'b0;

      repeat (4) @(negedge clk);
      chk32("q_done_left", q_done.size(), 32'd0);
      chk32("q_done0_left", q_done0.size(), 32'd0);
      chk32("q_wr_left", q_wr.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
